// File: rtl/seq_frame_tx_if.sv
// -----------------------------------------------------------------------------
// seq_frame_tx_if
//   Parallel payload handshake into the serial frame transmitter.
//   A transfer happens on a rising clk edge where tx_valid and tx_ready are
//   both high.
//
//   Signals
//     tx_data   [PAYLOAD_W]  payload, sampled on the transfer edge
//     tx_valid               producer has a payload available
//     tx_ready               transmitter is idle and can accept a payload
//
//   Modports
//     master  payload producer (drives tx_data / tx_valid)
//     slave   transmitter      (drives tx_ready)
// -----------------------------------------------------------------------------
interface seq_frame_tx_if #(
  parameter int PAYLOAD_W = 8
);
  logic [PAYLOAD_W-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/seq_frame_tx.sv
// -----------------------------------------------------------------------------
// seq_frame_tx
//   Send side of the 1011 sync-pattern serial link. A payload accepted over
//   the handshake is emitted one bit per clock on data_out as:
//     sync pattern (MSB first), payload (MSB first), [even parity], guard zeros.
//   The first sync bit is on the line the cycle after the transfer.
//
// Parameters
//   PAYLOAD_W     payload bits per frame (>=1)
//   SYNC_W        sync pattern length (>=1)
//   SYNC_PATTERN  sync bits, sent MSB first
//   GAP_CYCLES    guard zero cycles after the last frame bit (>=0)
//
// Ports
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   tx          handshake (seq_frame_tx_if.slave): tx_data, tx_valid, tx_ready
//   data_out    registered serial line
//   tx_active   high while a frame or its guard zeros are on the line
//   frame_done  one-cycle pulse coincident with the last frame bit
//
// Build option
//   PARITY_EN   when defined, an even parity bit (^payload) follows the
//               payload and frame_done moves onto that bit. When undefined
//               there is no parity state or logic.
// -----------------------------------------------------------------------------
module seq_frame_tx #(
  parameter int                PAYLOAD_W    = 8,
  parameter int                SYNC_W       = 4,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = 4'b1011,
  parameter int                GAP_CYCLES   = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  seq_frame_tx_if.slave tx,
  output logic          data_out,
  output logic          tx_active,
  output logic          frame_done
);

  // One counter serves every state; it is sized so the longest state
  // (sync, payload or guard) never wraps.
  localparam int SD_MAX  = (SYNC_W > PAYLOAD_W) ? SYNC_W : PAYLOAD_W;
  localparam int CNT_MAX = (GAP_CYCLES > SD_MAX) ? GAP_CYCLES : SD_MAX;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(PAYLOAD_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

`ifdef PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_PAR, S_GAP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA, S_GAP} state_t;
`endif

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [SYNC_W-1:0]    sync_sh;     // remaining sync bits, next one at MSB
  logic [PAYLOAD_W-1:0] payload_sh;  // latched payload, next bit at MSB
`ifdef PARITY_EN
  logic                 par_bit;     // even parity of the latched payload
`endif

  // Only IDLE accepts; tx_valid held high elsewhere is simply ignored.
  assign tx.tx_ready = (state == S_IDLE);

  // data_out always holds the bit of the state currently in 'state'; each
  // branch loads the bit for the cycle that follows the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      sync_sh    <= '0;
      payload_sh <= '0;
`ifdef PARITY_EN
      par_bit    <= 1'b0;
`endif
      data_out   <= 1'b0;
      tx_active  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          data_out <= 1'b0;
          if (tx.tx_valid && tx.tx_ready) begin
            state      <= S_SYNC;
            cnt        <= '0;
            data_out   <= SYNC_PATTERN[SYNC_W-1];
            sync_sh    <= SYNC_PATTERN << 1;
            payload_sh <= tx.tx_data;
`ifdef PARITY_EN
            par_bit    <= ^tx.tx_data;
`endif
            tx_active  <= 1'b1;
          end
        end

        S_SYNC: begin
          if (cnt == SYNC_LAST) begin
            state      <= S_DATA;
            cnt        <= '0;
            data_out   <= payload_sh[PAYLOAD_W-1];
            payload_sh <= payload_sh << 1;
`ifndef PARITY_EN
            // A one-bit payload makes the first data bit also the last.
            frame_done <= (PAYLOAD_W == 1);
`endif
          end else begin
            cnt      <= cnt + CNT_ONE;
            data_out <= sync_sh[SYNC_W-1];
            sync_sh  <= sync_sh << 1;
          end
        end

        S_DATA: begin
          if (cnt == DATA_LAST) begin
`ifdef PARITY_EN
            state      <= S_PAR;
            cnt        <= '0;
            data_out   <= par_bit;
            frame_done <= 1'b1;
`else
            cnt      <= '0;
            data_out <= 1'b0;
            if (GAP_CYCLES > 0) begin
              state <= S_GAP;
            end else begin
              state     <= S_IDLE;
              tx_active <= 1'b0;
            end
`endif
          end else begin
            cnt        <= cnt + CNT_ONE;
            data_out   <= payload_sh[PAYLOAD_W-1];
            payload_sh <= payload_sh << 1;
`ifndef PARITY_EN
            frame_done <= ((cnt + CNT_ONE) == DATA_LAST);
`endif
          end
        end

`ifdef PARITY_EN
        S_PAR: begin
          cnt      <= '0;
          data_out <= 1'b0;
          if (GAP_CYCLES > 0) begin
            state <= S_GAP;
          end else begin
            state     <= S_IDLE;
            tx_active <= 1'b0;
          end
        end
`endif

        S_GAP: begin
          data_out <= 1'b0;
          if (cnt == GAP_LAST) begin
            state     <= S_IDLE;
            cnt       <= '0;
            tx_active <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        default: begin
          state     <= S_IDLE;
          cnt       <= '0;
          data_out  <= 1'b0;
          tx_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_frame_tx.sv
`timescale 1ns/1ps
module tb_seq_frame_tx;
  localparam int                PAYLOAD_W    = 8;
  localparam int                SYNC_W       = 4;
  localparam logic [SYNC_W-1:0] SYNC_PATTERN = 4'b1011;
  localparam int                GAP_CYCLES   = 2;
`ifdef PARITY_EN
  localparam int FRAME_LEN = SYNC_W + PAYLOAD_W + 1;
`else
  localparam int FRAME_LEN = SYNC_W + PAYLOAD_W;
`endif
  localparam int PERIOD = FRAME_LEN + GAP_CYCLES + 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic data_out, tx_active, frame_done;
  logic z_data_out, z_tx_active, z_frame_done;

  int n_cmp = 0;
  int n_err = 0;
  bit exp_bits[$];

  seq_frame_tx_if #(.PAYLOAD_W(PAYLOAD_W)) tx_bus ();
  seq_frame_tx_if #(.PAYLOAD_W(PAYLOAD_W)) z_bus ();

  seq_frame_tx #(.PAYLOAD_W(PAYLOAD_W), .SYNC_W(SYNC_W), .SYNC_PATTERN(SYNC_PATTERN),
                 .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk(clk), .reset_n(reset_n), .tx(tx_bus.slave),
    .data_out(data_out), .tx_active(tx_active), .frame_done(frame_done));

  seq_frame_tx #(.PAYLOAD_W(PAYLOAD_W), .SYNC_W(SYNC_W), .SYNC_PATTERN(SYNC_PATTERN),
                 .GAP_CYCLES(0)) dut_nogap (
    .clk(clk), .reset_n(reset_n), .tx(z_bus.slave),
    .data_out(z_data_out), .tx_active(z_tx_active), .frame_done(z_frame_done));

  always #5 clk = ~clk;

  // Reference: the line image of one frame, straight from the framing rules.
  function automatic void build_frame(input logic [PAYLOAD_W-1:0] p);
    int ones = 0;
    exp_bits.delete();
    for (int i = SYNC_W - 1; i >= 0; i--) exp_bits.push_back(SYNC_PATTERN[i]);
    for (int i = PAYLOAD_W - 1; i >= 0; i--) begin
      exp_bits.push_back(p[i]);
      ones += int'(p[i]);
    end
`ifdef PARITY_EN
    exp_bits.push_back((ones % 2) == 1);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tx_bus.tx_valid = 1'b1;
    tx_bus.tx_data  = 8'hFF;
    z_bus.tx_valid  = 1'b0;
    z_bus.tx_data   = '0;
    repeat (3) tick();
    n_cmp++;
    if (data_out !== 1'b0 || tx_active !== 1'b0 || frame_done !== 1'b0 || tx_bus.tx_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_state: data_out=%b tx_active=%b frame_done=%b tx_ready=%b, want 0 0 0 1",
               data_out, tx_active, frame_done, tx_bus.tx_ready);
    end
    reset_n = 1'b1;
    tick();
    build_frame(8'hFF);
    n_cmp++;
    if (data_out !== exp_bits[0] || tx_active !== 1'b1 || tx_bus.tx_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_first_edge: data_out=%b tx_active=%b tx_ready=%b, want %b 1 0",
               data_out, tx_active, tx_bus.tx_ready, exp_bits[0]);
    end
    tx_bus.tx_valid = 1'b0;
    for (int k = 0; k < 4 * PERIOD && tx_bus.tx_ready !== 1'b1; k++) tick();
    n_cmp++;
    if (tx_bus.tx_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_drain_timeout: tx_ready=%b, want 1", tx_bus.tx_ready);
    end
  endtask

  task automatic test_known_frames();
    logic [PAYLOAD_W-1:0] pats [5];
    logic [31:0] got;
    logic [31:0] want;
    pats = '{8'hA5, 8'h01, 8'h00, 8'hFF, 8'h80};
    foreach (pats[n]) begin
      build_frame(pats[n]);
      got = '0;
      tx_bus.tx_data  = pats[n];
      tx_bus.tx_valid = 1'b1;
      tick();
      tx_bus.tx_valid = 1'b0;
      tx_bus.tx_data  = PAYLOAD_W'($urandom);
      for (int i = 0; i < FRAME_LEN; i++) begin
        got = {got[30:0], data_out};
        n_cmp++;
        if (data_out !== exp_bits[i] || frame_done !== (i == FRAME_LEN - 1) ||
            tx_active !== 1'b1 || tx_bus.tx_ready !== 1'b0) begin
          n_err++;
          $display("FAIL known_bit p=%h i=%0d: data_out=%b frame_done=%b tx_active=%b tx_ready=%b, want %b %b 1 0",
                   pats[n], i, data_out, frame_done, tx_active, tx_bus.tx_ready,
                   exp_bits[i], (i == FRAME_LEN - 1));
        end
        tick();
      end
      for (int g = 0; g < GAP_CYCLES; g++) begin
        n_cmp++;
        if (data_out !== 1'b0 || tx_active !== 1'b1 || tx_bus.tx_ready !== 1'b0 || frame_done !== 1'b0) begin
          n_err++;
          $display("FAIL known_gap p=%h g=%0d: data_out=%b tx_active=%b tx_ready=%b frame_done=%b, want 0 1 0 0",
                   pats[n], g, data_out, tx_active, tx_bus.tx_ready, frame_done);
        end
        tick();
      end
      n_cmp++;
      if (data_out !== 1'b0 || tx_active !== 1'b0 || tx_bus.tx_ready !== 1'b1) begin
        n_err++;
        $display("FAIL known_idle p=%h: data_out=%b tx_active=%b tx_ready=%b, want 0 0 1",
                 pats[n], data_out, tx_active, tx_bus.tx_ready);
      end
      // Literal line images for the two documented frames.
      want = 32'hFFFF_FFFF;
`ifdef PARITY_EN
      if (pats[n] == 8'hA5) want = 32'b1011_1010_0101_0;
      if (pats[n] == 8'h01) want = 32'b1011_0000_0001_1;
`else
      if (pats[n] == 8'hA5) want = 32'b1011_1010_0101;
`endif
      if (want != 32'hFFFF_FFFF) begin
        n_cmp++;
        if (got !== want) begin
          n_err++;
          $display("FAIL known_image p=%h: line=%b, want %b", pats[n], got, want);
        end
      end
    end
  endtask

  task automatic test_random_frames();
    logic [PAYLOAD_W-1:0] p;
    for (int n = 0; n < 20; n++) begin
      p = PAYLOAD_W'($urandom);
      build_frame(p);
      tx_bus.tx_data  = p;
      tx_bus.tx_valid = 1'b1;
      tick();
      for (int i = 0; i < FRAME_LEN; i++) begin
        tx_bus.tx_valid = 1'($urandom);
        tx_bus.tx_data  = PAYLOAD_W'($urandom);
        n_cmp++;
        if (data_out !== exp_bits[i] || frame_done !== (i == FRAME_LEN - 1) || tx_bus.tx_ready !== 1'b0) begin
          n_err++;
          $display("FAIL rand_bit p=%h i=%0d: data_out=%b frame_done=%b tx_ready=%b, want %b %b 0",
                   p, i, data_out, frame_done, tx_bus.tx_ready, exp_bits[i], (i == FRAME_LEN - 1));
        end
        tick();
      end
      tx_bus.tx_valid = 1'b0;
      repeat (GAP_CYCLES) tick();
      repeat ($urandom_range(0, 2)) tick();
      n_cmp++;
      if (data_out !== 1'b0 || tx_active !== 1'b0 || tx_bus.tx_ready !== 1'b1) begin
        n_err++;
        $display("FAIL rand_idle p=%h: data_out=%b tx_active=%b tx_ready=%b, want 0 0 1",
                 p, data_out, tx_active, tx_bus.tx_ready);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [PAYLOAD_W-1:0] pl [2];
    pl = '{8'h3C, 8'hC3};
    tx_bus.tx_data  = pl[0];
    tx_bus.tx_valid = 1'b1;
    tick();
    tx_bus.tx_data = pl[1];
    for (int f = 0; f < 2; f++) begin
      build_frame(pl[f]);
      for (int i = 0; i < FRAME_LEN; i++) begin
        n_cmp++;
        if (data_out !== exp_bits[i] || frame_done !== (i == FRAME_LEN - 1)) begin
          n_err++;
          $display("FAIL b2b_bit f=%0d i=%0d: data_out=%b frame_done=%b, want %b %b",
                   f, i, data_out, frame_done, exp_bits[i], (i == FRAME_LEN - 1));
        end
        tick();
        if (f == 1) tx_bus.tx_valid = 1'b0;
      end
      for (int z = 0; z <= GAP_CYCLES; z++) begin
        n_cmp++;
        if (data_out !== 1'b0 || tx_bus.tx_ready !== (z == GAP_CYCLES)) begin
          n_err++;
          $display("FAIL b2b_gap f=%0d z=%0d: data_out=%b tx_ready=%b, want 0 %b",
                   f, z, data_out, tx_bus.tx_ready, (z == GAP_CYCLES));
        end
        if (z < GAP_CYCLES || f == 0) tick();
      end
    end
    tx_bus.tx_valid = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    logic [PAYLOAD_W-1:0] p;
    p = PAYLOAD_W'($urandom);
    build_frame(p);
    tx_bus.tx_data  = p;
    tx_bus.tx_valid = 1'b1;
    tick();
    tx_bus.tx_valid = 1'b0;
    for (int i = 0; i <= SYNC_W + 3; i++) begin
      n_cmp++;
      if (data_out !== exp_bits[i]) begin
        n_err++;
        $display("FAIL midrst_pre i=%0d: data_out=%b, want %b", i, data_out, exp_bits[i]);
      end
      if (i < SYNC_W + 3) tick();
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (data_out !== 1'b0 || tx_active !== 1'b0 || frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_async: data_out=%b tx_active=%b frame_done=%b, want 0 0 0",
               data_out, tx_active, frame_done);
    end
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++;
      if (data_out !== 1'b0 || tx_active !== 1'b0 || tx_bus.tx_ready !== 1'b1) begin
        n_err++;
        $display("FAIL midrst_quiet k=%0d: data_out=%b tx_active=%b tx_ready=%b, want 0 0 1",
                 k, data_out, tx_active, tx_bus.tx_ready);
      end
    end
    p = PAYLOAD_W'($urandom);
    build_frame(p);
    tx_bus.tx_data  = p;
    tx_bus.tx_valid = 1'b1;
    tick();
    tx_bus.tx_valid = 1'b0;
    for (int i = 0; i < FRAME_LEN; i++) begin
      n_cmp++;
      if (data_out !== exp_bits[i] || frame_done !== (i == FRAME_LEN - 1)) begin
        n_err++;
        $display("FAIL midrst_post p=%h i=%0d: data_out=%b frame_done=%b, want %b %b",
                 p, i, data_out, frame_done, exp_bits[i], (i == FRAME_LEN - 1));
      end
      tick();
    end
    repeat (GAP_CYCLES) tick();
  endtask

  task automatic test_loopback_detect();
    logic [3:0] hist;
    int hits[$];
    hist = 4'b0000;
    tx_bus.tx_data  = 8'h00;
    tx_bus.tx_valid = 1'b1;
    tick();
    for (int c = 0; c < 3 * PERIOD; c++) begin
      hist = {hist[2:0], data_out};
      if (hist == 4'b1011) hits.push_back(c);
      if (c == 2 * PERIOD) tx_bus.tx_valid = 1'b0;
      tick();
    end
    n_cmp++;
    if (hits.size() != 3) begin
      n_err++;
      $display("FAIL loop_count: detections=%0d, want 3", hits.size());
    end
    for (int f = 0; f < hits.size() && f < 3; f++) begin
      n_cmp++;
      if (hits[f] != f * PERIOD + SYNC_W - 1) begin
        n_err++;
        $display("FAIL loop_pos f=%0d: cycle=%0d, want %0d", f, hits[f], f * PERIOD + SYNC_W - 1);
      end
    end
    repeat (PERIOD) tick();
  endtask

  task automatic test_zero_gap();
    logic [PAYLOAD_W-1:0] pl [2];
    pl[0] = PAYLOAD_W'($urandom);
    pl[1] = PAYLOAD_W'($urandom);
    z_bus.tx_data  = pl[0];
    z_bus.tx_valid = 1'b1;
    tick();
    z_bus.tx_data = pl[1];
    for (int f = 0; f < 2; f++) begin
      build_frame(pl[f]);
      for (int i = 0; i < FRAME_LEN; i++) begin
        n_cmp++;
        if (z_data_out !== exp_bits[i] || z_frame_done !== (i == FRAME_LEN - 1) || z_tx_active !== 1'b1) begin
          n_err++;
          $display("FAIL nogap_bit f=%0d i=%0d: data_out=%b frame_done=%b tx_active=%b, want %b %b 1",
                   f, i, z_data_out, z_frame_done, z_tx_active, exp_bits[i], (i == FRAME_LEN - 1));
        end
        tick();
        if (f == 1) z_bus.tx_valid = 1'b0;
      end
      n_cmp++;
      if (z_data_out !== 1'b0 || z_tx_active !== 1'b0 || z_bus.tx_ready !== 1'b1) begin
        n_err++;
        $display("FAIL nogap_idle f=%0d: data_out=%b tx_active=%b tx_ready=%b, want 0 0 1",
                 f, z_data_out, z_tx_active, z_bus.tx_ready);
      end
      if (f == 0) tick();
    end
    z_bus.tx_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_known_frames();
    test_random_frames();
    test_back_to_back();
    test_reset_mid_frame();
    test_loopback_detect();
    test_zero_gap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d mismatched=%0d", n_cmp, n_err);
    $fatal(1, "time limit");
  end
endmodule
